// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register for the MIPS datapath.
// It tracks the outstanding data-memory request and keeps a saturating count of memory-wait cycles.
module ex_mem_latch #(
   parameter int CNT_W  = 16,
   parameter int WSEL_W = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              en,
   input  logic              stall,
   input  logic              flush,
   input  logic              dhit,
   input  logic              in_halt,
   input  logic              in_RegWr,
   input  logic              in_MemToReg,
   input  logic              in_dREN,
   input  logic              in_dWEN,
   input  logic              in_jal,
   input  logic              in_lui,
   input  logic [WSEL_W-1:0] in_wsel,
   input  logic [31:0]       in_aluout,
   input  logic [31:0]       in_store,
   input  logic [31:0]       in_npc,
   input  logic [31:0]       in_instr,
   output logic              out_halt,
   output logic              out_RegWr,
   output logic              out_MemToReg,
   output logic              out_dREN,
   output logic              out_dWEN,
   output logic              out_jal,
   output logic              out_lui,
   output logic [WSEL_W-1:0] out_wsel,
   output logic [31:0]       out_aluout,
   output logic [31:0]       out_store,
   output logic [31:0]       out_npc,
   output logic [31:0]       out_instr,
   output logic              mem_pending,
   output logic [CNT_W-1:0]  memwait_cnt
);
   logic w_pending, w_bubble, w_load, w_retire, w_wait;
   assign w_pending   = out_dREN | out_dWEN;
   assign w_bubble    = en & flush;
   // a pending access may only be replaced on the edge it completes
   assign w_load      = en & ~stall & (~w_pending | dhit);
   assign w_retire    = dhit & w_pending;
   assign w_wait      = w_pending & ~dhit;
   assign mem_pending = w_pending;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_halt     <= 1'b0;
         out_RegWr    <= 1'b0;
         out_MemToReg <= 1'b0;
         out_dREN     <= 1'b0;
         out_dWEN     <= 1'b0;
         out_jal      <= 1'b0;
         out_lui      <= 1'b0;
         out_wsel     <= '0;
         out_aluout   <= '0;
         out_store    <= '0;
         out_npc      <= '0;
         out_instr    <= '0;
      end else if (w_bubble) begin
         out_RegWr    <= 1'b0;
         out_MemToReg <= 1'b0;
         out_dREN     <= 1'b0;
         out_dWEN     <= 1'b0;
         out_jal      <= 1'b0;
         out_lui      <= 1'b0;
         out_wsel     <= '0;
         out_aluout   <= '0;
         out_store    <= '0;
         out_npc      <= '0;
         out_instr    <= '0;
      end else if (w_load) begin
         out_halt     <= out_halt | in_halt;
         out_RegWr    <= in_RegWr;
         out_MemToReg <= in_MemToReg;
         out_dREN     <= in_dREN;
         out_dWEN     <= in_dWEN;
         out_jal      <= in_jal;
         out_lui      <= in_lui;
         out_wsel     <= in_wsel;
         out_aluout   <= in_aluout;
         out_store    <= in_store;
         out_npc      <= in_npc;
         out_instr    <= in_instr;
      end else if (w_retire) begin
         out_dREN     <= 1'b0;
         out_dWEN     <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         memwait_cnt <= '0;
      else if (w_wait && !(&memwait_cnt))
         memwait_cnt <= memwait_cnt + CNT_W'(1);
   end
endmodule
